// File: rtl/tc_host_pkg.sv
// Shared types and encodings for the tensor-core host driver: driver FSM states,
// controller state codes and load-row type codes.
package tc_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_GO     = 3'd4,
      ST_WAIT   = 3'd5,
      ST_DRAIN  = 3'd6,
      ST_DONE   = 3'd7
   } drv_state_e;

   localparam logic [1:0] TC_IDLE = 2'b00;
   localparam logic [1:0] TC_LOAD = 2'b01;
   localparam logic [1:0] TC_COMP = 2'b10;
   localparam logic [1:0] TC_SEND = 2'b11;

   localparam logic TYPE_A = 1'b0;
   localparam logic TYPE_B = 1'b1;

endpackage

// File: rtl/tc_row_counter.sv
// Loadable up-counter with a terminal-count flag (count == i_last), used for
// both the load-row count and the result-capture count.
module tc_row_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_count,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   // load has priority over increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= {W{1'b0}};
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_inc) begin
         r_count <= r_count + W'(1'b1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/tc_host_drv.sv
// Host-side driver for the tensor-core controller: sequences A/B rows onto the
// load port and re-presents the result stream as indexed words.
// Optional running result checksum output: define TC_HOST_DRV_CHECKSUM_EN.
module tc_host_drv
   import tc_host_pkg::*;
#(
   parameter int M      = 16,
   parameter int K      = 16,
   parameter int N      = 16,
   parameter int DW_MUL = 8,
   parameter int DW_ADD = 32,
   parameter int DW_ROW = DW_MUL*K,
   parameter int DW_IDX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DW_ROW-1:0] src_row,
   output logic              tc_enable,
   output logic [DW_ROW-1:0] tc_in_i,
   output logic              tc_in_type,
   output logic              tc_in_state,
   input  logic [1:0]        tc_out_state,
   input  logic              tc_res_strobe,
   input  logic [DW_ADD-1:0] tc_out_i,
   output logic              res_valid,
   output logic [DW_ADD-1:0] res_data,
   output logic [DW_IDX-1:0] res_idx,
   output logic              busy,
`ifdef TC_HOST_DRV_CHECKSUM_EN
   output logic [DW_ADD-1:0] res_checksum,
`endif
   output logic              done
);

   localparam logic [DW_IDX-1:0] LAST_A  = DW_IDX'(M-1);
   localparam logic [DW_IDX-1:0] LAST_B  = DW_IDX'(N-1);
   localparam logic [DW_IDX-1:0] LAST_MN = DW_IDX'(M*N-1);

   drv_state_e        r_state, w_state_nx;
   logic              r_src_ready, r_tc_enable, r_tc_in_type, r_tc_in_state;
   logic [DW_ROW-1:0] r_tc_in_i;
   logic              r_res_valid, r_busy, r_done, r_cap_pend;
   logic [DW_ADD-1:0] r_res_data;
   logic [DW_IDX-1:0] r_res_idx;

   logic              w_accept, w_cap, w_en_nx, w_type_nx, w_ist_nx, w_rdy_nx;
   logic              w_done_nx, w_pend_nx, w_ld_clr, w_ld_tc, w_res_clr, w_res_tc;
   logic [DW_ROW-1:0] w_row_nx;
   logic [DW_IDX-1:0] w_ld_last, w_ld_cnt, w_res_cnt;
   logic              w_unused;

   assign w_accept = src_valid && r_src_ready;
   assign w_cap    = r_cap_pend;
   assign w_unused = ^w_ld_cnt;

   tc_row_counter #(.W(DW_IDX)) u_load_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ld_clr),
      .i_load_val ({DW_IDX{1'b0}}),
      .i_inc      (w_accept),
      .i_last     (w_ld_last),
      .o_count    (w_ld_cnt),
      .o_tc       (w_ld_tc)
   );

   tc_row_counter #(.W(DW_IDX)) u_res_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_res_clr),
      .i_load_val ({DW_IDX{1'b0}}),
      .i_inc      (w_cap),
      .i_last     (LAST_MN),
      .o_count    (w_res_cnt),
      .o_tc       (w_res_tc)
   );

   // next state and next value of every registered controller-facing output
   always_comb begin
      w_state_nx = r_state;
      w_en_nx    = 1'b0;
      w_ist_nx   = 1'b0;
      w_row_nx   = r_tc_in_i;
      w_type_nx  = r_tc_in_type;
      w_rdy_nx   = 1'b0;
      w_done_nx  = 1'b0;
      w_pend_nx  = 1'b0;
      w_ld_clr   = 1'b0;
      w_ld_last  = LAST_A;
      w_res_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (tc_out_state == TC_IDLE)) begin
               w_state_nx = ST_ARM;
               w_en_nx    = 1'b1;
               w_ist_nx   = 1'b1;
               w_type_nx  = TYPE_A;
               w_row_nx   = {DW_ROW{1'b0}};
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_ARM: begin
            w_state_nx = ST_LOAD_A;
            w_rdy_nx   = 1'b1;
            w_ld_clr   = 1'b1;
            w_res_clr  = 1'b1;
         end
         ST_LOAD_A, ST_LOAD_B: begin
            w_ld_last = (r_state == ST_LOAD_A) ? LAST_A : LAST_B;
            w_rdy_nx  = 1'b1;
            if (w_accept) begin
               w_en_nx   = 1'b1;
               w_row_nx  = src_row;
               w_type_nx = (r_state == ST_LOAD_A) ? TYPE_A : TYPE_B;
               // ready drops for a cycle on the last row of each matrix
               if (w_ld_tc) begin
                  w_rdy_nx   = 1'b0;
                  w_ld_clr   = 1'b1;
                  w_state_nx = (r_state == ST_LOAD_A) ? ST_LOAD_B : ST_GO;
               end else begin
                  w_rdy_nx   = 1'b1;
               end
            end else begin
               w_en_nx = 1'b0;
            end
         end
         ST_GO: begin
            w_state_nx = ST_WAIT;
            w_en_nx    = 1'b1;
            w_ist_nx   = 1'b1;
            w_row_nx   = {DW_ROW{1'b0}};
         end
         ST_WAIT: begin
            w_en_nx = 1'b1;
            if (tc_res_strobe && (tc_out_state == TC_SEND)) begin
               w_state_nx = ST_DRAIN;
               w_pend_nx  = 1'b1;
            end else begin
               w_state_nx = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            // a pending capture at the terminal count is the last word
            if (r_cap_pend && w_res_tc) begin
               w_state_nx = ST_DONE;
               w_en_nx    = 1'b0;
               w_pend_nx  = 1'b0;
            end else begin
               w_en_nx    = 1'b1;
               w_pend_nx  = tc_res_strobe;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b1;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // state, outputs and result capture registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_src_ready   <= 1'b0;
         r_tc_enable   <= 1'b0;
         r_tc_in_i     <= {DW_ROW{1'b0}};
         r_tc_in_type  <= 1'b0;
         r_tc_in_state <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_data    <= {DW_ADD{1'b0}};
         r_res_idx     <= {DW_IDX{1'b0}};
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_cap_pend    <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_src_ready   <= w_rdy_nx;
         r_tc_enable   <= w_en_nx;
         r_tc_in_i     <= w_row_nx;
         r_tc_in_type  <= w_type_nx;
         r_tc_in_state <= w_ist_nx;
         r_res_valid   <= w_cap;
         r_busy        <= (w_state_nx != ST_IDLE);
         r_done        <= w_done_nx;
         r_cap_pend    <= w_pend_nx;
         if (w_cap) begin
            r_res_data <= tc_out_i;
            r_res_idx  <= w_res_cnt;
         end
      end
   end

`ifdef TC_HOST_DRV_CHECKSUM_EN
   logic [DW_ADD-1:0] r_checksum;

   // wrapping sum of captured words, cleared when a job is armed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_checksum <= {DW_ADD{1'b0}};
      end else if (r_state == ST_ARM) begin
         r_checksum <= {DW_ADD{1'b0}};
      end else if (w_cap) begin
         r_checksum <= r_checksum + tc_out_i;
      end
   end

   assign res_checksum = r_checksum;
`endif

   assign src_ready   = r_src_ready;
   assign tc_enable   = r_tc_enable;
   assign tc_in_i     = r_tc_in_i;
   assign tc_in_type  = r_tc_in_type;
   assign tc_in_state = r_tc_in_state;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_idx     = r_res_idx;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_tc_host_drv.sv
// Self-checking bench for tc_host_drv (M=K=N=4): a small controller model
// consumes the written rows and streams results; a scoreboard checks them.
module tb_tc_host_drv;

   localparam int M = 4, K = 4, N = 4, DW_MUL = 8, DW_ADD = 32, DW_ROW = 32, DW_IDX = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              src_valid = 1'b0;
   logic              src_ready;
   logic [DW_ROW-1:0] src_row = '0;
   logic              tc_enable;
   logic [DW_ROW-1:0] tc_in_i;
   logic              tc_in_type;
   logic              tc_in_state;
   logic [1:0]        tc_out_state = 2'b00;
   logic              tc_res_strobe = 1'b0;
   logic [DW_ADD-1:0] tc_out_i = '0;
   logic              res_valid;
   logic [DW_ADD-1:0] res_data;
   logic [DW_IDX-1:0] res_idx;
   logic              busy;
   logic              done;
`ifdef TC_HOST_DRV_CHECKSUM_EN
   logic [DW_ADD-1:0] res_checksum;
`endif

   tc_host_drv #(.M(M), .K(K), .N(N), .DW_MUL(DW_MUL), .DW_ADD(DW_ADD),
                 .DW_ROW(DW_ROW), .DW_IDX(DW_IDX)) dut (
      .clk(clk), .reset(reset), .start(start), .src_valid(src_valid),
      .src_ready(src_ready), .src_row(src_row), .tc_enable(tc_enable),
      .tc_in_i(tc_in_i), .tc_in_type(tc_in_type), .tc_in_state(tc_in_state),
      .tc_out_state(tc_out_state), .tc_res_strobe(tc_res_strobe), .tc_out_i(tc_out_i),
      .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .busy(busy),
`ifdef TC_HOST_DRV_CHECKSUM_EN
      .res_checksum(res_checksum),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [47:0] exp_q[$];
   logic [47:0] mon_exp;
   int          wr_cnt, pulse_cnt, done_cnt, n_valid;
   logic [7:0]  types;
   logic [31:0] wr_rows[8];
   logic [31:0] ctl_res[16];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: per-job counters cleared on a sampled start, outputs sampled on negedge
   always @(clk) begin
      if (clk) begin
         if (start) begin
            wr_cnt = 0; pulse_cnt = 0; done_cnt = 0; n_valid = 0; types = '0;
         end
      end else if (!reset) begin
         if (tc_in_state) begin
            pulse_cnt++;
         end else if (tc_enable && pulse_cnt == 1) begin
            if (wr_cnt < 8) begin
               wr_rows[wr_cnt] = tc_in_i;
               types[wr_cnt]   = tc_in_type;
            end
            wr_cnt++;
         end
         if (res_valid) begin
            n_valid++;
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hxxxx_xxxx_xxxx;
            check("res_word", {res_idx, res_data}, mon_exp);
         end
         if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 1'b0);
`ifdef TC_HOST_DRV_CHECKSUM_EN
            check("checksum", res_checksum, 32'd40);
`endif
         end
      end
   end

   // Row r<4: A identity row r; row r>=4: B column j=r-4, every element j+1
   function automatic logic [31:0] mk_row(input int r);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < K; k++) begin
         if (r < M) v[8*k +: 8] = (k == r) ? 8'd1 : 8'd0;
         else       v[8*k +: 8] = 8'(r - M + 1);
      end
      return v;
   endfunction

   task automatic feed_rows(input int nrows, input int gap);
      int guard;
      for (int r = 0; r < nrows; r++) begin
         src_row   = mk_row(r);
         src_valid = 1'b1;
         guard     = 0;
         while (!src_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) check("feed_timeout", guard, 0);
         @(negedge clk);
         if (gap > 0) begin
            src_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      src_valid = 1'b0;
   endtask

   task automatic run_job(input int gap, input int extra, input string tag);
      int c;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            exp_q.push_back({16'(i*N + j), 32'(j + 1)});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tc_out_state = 2'b01;
      feed_rows(M + N, gap);
      c = 0;
      while (pulse_cnt < 2 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_go_pulse"}, pulse_cnt, 2);
      // controller model: multiply the rows that were actually written
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) begin
            ctl_res[i*N + j] = '0;
            for (int k = 0; k < K; k++)
               ctl_res[i*N + j] += 32'(wr_rows[i][8*k +: 8]) * 32'(wr_rows[M + j][8*k +: 8]);
         end
      tc_out_state = 2'b11;
      for (int s = 0; s <= 16 + extra; s++) begin
         if (s > 0) tc_out_i = (s - 1 < 16) ? ctl_res[s - 1] : (32'hdead_0000 | 32'(s));
         tc_res_strobe = (s < 16 + extra);
         @(negedge clk);
      end
      tc_res_strobe = 1'b0;
      c = 0;
      while (done_cnt < 1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      tc_out_state = 2'b00;
      repeat (4) @(negedge clk);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_wr_cnt"}, wr_cnt, 8);
      check({tag, "_types"}, types, 8'b1111_0000);
      check({tag, "_n_valid"}, n_valid, 16);
      check({tag, "_q_empty"}, exp_q.size(), 0);
      check({tag, "_busy_idle"}, busy, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outs", {src_ready, tc_enable, tc_in_i, tc_in_type, tc_in_state,
                           res_valid, res_data, res_idx, busy, done}, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_outs", {src_ready, tc_enable, tc_in_state, busy, done}, 5'd0);

      run_job(0, 0, "b2b");
      run_job(2, 0, "bubbles");

      // start while controller is not idle must be ignored
      tc_out_state = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_start_ign", busy, 1'b0);
      check("pulse_start_ign", pulse_cnt, 0);
      check("en_start_ign", tc_enable, 1'b0);
      tc_out_state = 2'b00;
      @(negedge clk);

      // abort after 3 A rows
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed_rows(3, 0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_outs", {src_ready, tc_enable, tc_in_i, tc_in_type, tc_in_state,
                           res_valid, res_data, res_idx, busy, done}, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_no_done", done_cnt, 0);

      run_job(0, 0, "after_abort");
      run_job(0, 4, "extra_strobes");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tc_host_drv.md
Name: tc_host_drv

Overview:
- Host-side driver for the tensor-core controller's testbench-facing port.
- Transmit side: accepts matrix rows from a valid/ready source and sequences them onto the controller load interface (`tc_in_i`, `tc_in_type`, `tc_in_state`, `tc_enable`).
- Receive side: captures the M*N result stream the controller emits on `tc_out_i` and re-presents it as indexed, valid-qualified words.
- Sits between a DMA/testbench source and the controller, so upper layers never handle the controller's state encoding.

Parameters:
- M, 16, rows of A and of the result.
- K, 16, inner dimension; elements per load row.
- N, 16, columns of B and of the result.
- DW_MUL, 8, element width of A/B.
- DW_ADD, 32, result word width.
- DW_ROW, DW_MUL*K, load row width (derived).
- DW_IDX, 16, width of the result index and counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a job when in IDLE.
- src_valid  in  1  source row valid.
- src_ready  out  1  driver accepts a row.
- src_row  in  DW_ROW  row data; element i at [DW_MUL*i +: DW_MUL].
- tc_enable  out  1  controller enable.
- tc_in_i  out  DW_ROW  controller load row.
- tc_in_type  out  1  0 = A row, 1 = B row (B is supplied as N rows of K, column-major).
- tc_in_state  out  1  controller state-advance pulse.
- tc_out_state  in  2  controller state: 00 idle, 01 loading, 10 computing, 11 all_send.
- tc_res_strobe  in  1  high on cycles where the controller updates `tc_out_i`; the new value is stable one cycle later.
- tc_out_i  in  DW_ADD  controller result word.
- res_valid  out  1  result word valid (one-cycle pulse per word, no backpressure).
- res_data  out  DW_ADD  result word.
- res_idx  out  DW_IDX  row-major result index, 0..M*N-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result.

Behaviour:
- Register timing:
  - All outputs are registered.
  - Reset (asynchronous) drives every output to 0, counters to 0 and state to IDLE.
  - Reset mid-job aborts the job immediately. Rows already accepted are lost, and no done pulse is issued.
- States: IDLE, ARM, LOAD_A, LOAD_B, GO, WAIT, DRAIN, DONE.
- IDLE:
  - start && tc_out_state==00 -> ARM.
  - start is ignored in every other state, and in IDLE when tc_out_state!=00.
- ARM: for one cycle drive tc_enable=1, tc_in_state=1, tc_in_type=0; then -> LOAD_A.
- LOAD_A / LOAD_B:
  - src_ready=1.
  - On an accept (src_valid && src_ready) in cycle t, cycle t+1 presents tc_enable=1, tc_in_state=0, tc_in_i=src_row, tc_in_type=0 (LOAD_A) or 1 (LOAD_B).
  - Cycles with no accept present tc_enable=0, which stalls the controller; no spurious row write is allowed.
  - The row counter increments on each accept.
  - LOAD_A: after M accepts -> LOAD_B, with src_ready dropping in the same cycle as the M-th accept registers.
  - LOAD_B: after N accepts -> GO.
  - src_ready is 0 outside the LOAD states.
- GO: for one cycle drive tc_enable=1, tc_in_state=1, tc_in_i=0; then -> WAIT. The final B row write and the GO pulse are on consecutive cycles, never the same cycle.
- WAIT: tc_enable=1 and tc_in_state=0. On the first tc_res_strobe seen while tc_out_state==11 -> DRAIN, and arm capture for the following cycle.
- DRAIN:
  - Each cycle after a strobe, latch tc_out_i into res_data, pulse res_valid, and set res_idx to the capture count.
  - Strobes after the M*N-th are ignored.
  - After M*N captures -> DONE.
- DONE:
  - Pulse done for one cycle, drop tc_enable, then -> IDLE.
  - busy falls on the same edge done rises.
- Simultaneous events: a start arriving in DONE is dropped; the caller re-issues it once busy==0.

Optional Feature:
- Macro: TC_HOST_DRV_CHECKSUM_EN.
- With it defined:
  - Adds output res_checksum [DW_ADD-1:0].
  - It is a wrapping (mod 2^DW_ADD) sum of all captured res_data words.
  - Cleared on ARM, stable from the done pulse until the next ARM.
- Without it: the port and the adder are absent.

Decomposition:
- Package tc_host_pkg holds:
  - the driver state enum;
  - controller state codes TC_IDLE=2'b00, TC_LOAD=2'b01, TC_COMP=2'b10, TC_SEND=2'b11;
  - type codes TYPE_A=1'b0, TYPE_B=1'b1.
- One sub-module, tc_row_counter: a loadable up-counter with terminal-count flag. It is instantiated for the load count and for the result count.

Test Plan:
- M=K=N=4, A=identity, B=j+1 for all entries of column j; start, rows streamed back-to-back -> 4+4 row writes, with tc_in_type sequence 0,0,0,0,1,1,1,1. Results row-major 1,2,3,4 repeated per row; res_idx 0..15; done once.
- Source with src_valid toggled 1,0,0,1 -> tc_enable low on every bubble cycle; write count still exactly 8; results identical to the back-to-back case.
- start while tc_out_state==01 -> stays IDLE; busy=0; tc_in_state never asserted.
- Assert reset after 3 A rows -> all outputs 0 next edge; a fresh start then completes a full job with correct results.
- Strobe stream longer than M*N (20 strobes for 16 results) -> exactly 16 res_valid pulses, no 17th.
- With TC_HOST_DRV_CHECKSUM_EN and the first scenario's data -> res_checksum == 40 at done.
